// File: rtl/demux14_reg_pkg.sv
// Shared definitions for the registered 1-to-4 lane distributor.
package demux14_reg_pkg;

  localparam int NLANE  = 4;
  localparam int DW_DEF = 2;

  typedef logic [1:0] lane_idx_t;

  // One-hot lane decode; also drives the per-lane write-hit pulse.
  function automatic logic [NLANE-1:0] lane_onehot(input lane_idx_t idx);
    logic [NLANE-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux14_reg_edge_rise.sv
// Rising-edge detector for an already-synchronous level input.
// RST_VAL=1 suppresses a spurious edge when the input is high at reset release.
module demux14_reg_edge_rise #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= RST_VAL;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/demux14_reg.sv
// Registered 1-to-4 demultiplexer: a wr rising edge stores din into lane[sel].
// Optional macro SCAN_EN adds a prescaled lane scanner (scan_f / scan_idx).
module demux14_reg
  import demux14_reg_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  lane_idx_t             sel,
  input  logic [DW-1:0]         din,
  input  logic                  wr,
  input  logic                  clr,
  output logic [NLANE*DW-1:0]   f,
  output logic [NLANE-1:0]      hit,
  output lane_idx_t             last,
  output logic [7:0]            wcnt
`ifdef SCAN_EN
  ,
  output logic [DW-1:0]         scan_f,
  output lane_idx_t             scan_idx
`endif
);

  logic [DW-1:0] lane [NLANE];
  logic          wr_edge;

  demux14_reg_edge_rise #(.RST_VAL(1'b1)) u_wr_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (wr),
    .rise (wr_edge)
  );

  // clr wins over a coincident write edge; that edge is still consumed by the detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NLANE; i++) lane[i] <= '0;
      hit  <= '0;
      last <= '0;
      wcnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < NLANE; i++) lane[i] <= '0;
      hit <= '0;
    end else if (wr_edge) begin
      lane[sel] <= din;
      hit       <= lane_onehot(sel);
      last      <= sel;
      wcnt      <= wcnt + 8'd1;
    end else begin
      hit <= '0;
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_pack
    assign f[g*DW +: DW] = lane[g];
  end

`ifdef SCAN_EN
  localparam logic [7:0] SCAN_TC = 8'(SCAN_DIV - 1);

  logic [7:0] scan_cnt;
  lane_idx_t  scan_nxt;

  assign scan_nxt = scan_idx + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      scan_f   <= '0;
    end else if (clr) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      scan_f   <= '0;
    end else if (scan_cnt == SCAN_TC) begin
      scan_cnt <= '0;
      scan_idx <= scan_nxt;
      scan_f   <= lane[scan_nxt];
    end else begin
      scan_cnt <= scan_cnt + 8'd1;
    end
  end
`else
  localparam int unused_scan_div = SCAN_DIV;
`endif

endmodule

// File: doc/demux14_reg.md
Name: demux14_reg

Overview:
- Registered 1-to-4 demultiplexer/distributor, the write-side counterpart of the board's 4-to-1 lane selector.
- A rising edge on a write strobe stores a DW-bit data value into one of four lane registers, chosen by a 2-bit select.
- All four lanes are held and presented in parallel, with a per-lane write-hit pulse and write bookkeeping for LED/debug display.

Parameters:
- DW, 2, width of each lane and of din
- SCAN_DIV, 4, cycles per scan step (used only when SCAN_EN is defined); legal range 1..256

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- sel  in  2  destination lane index, 0..3
- din  in  DW  data to store
- wr  in  1  write strobe, level input; a write fires on its 0->1 transition only
- clr  in  1  synchronous clear of all lanes, active-high
- f  out  4*DW  packed lanes: f[DW-1:0]=lane0 … f[4*DW-1:3*DW]=lane3
- hit  out  4  one-hot, high for exactly one cycle on the lane just written
- last  out  2  index of the most recently written lane
- wcnt  out  8  count of completed writes, wraps 255->0
- scan_f  out  DW  scanned lane value (SCAN_EN only)
- scan_idx  out  2  lane index currently scanned (SCAN_EN only)

Behaviour:
- Reset (rst=0, async):
  - lanes=0, hit=0, last=0, wcnt=0
  - wr_q=1, so a wr held high across reset release does not cause a write
  - scan_idx=0, scan counter=0
- Edge detect: wr_q <= wr every cycle; wr_edge = wr & ~wr_q, combinational from the current wr.
- Write, when wr_edge=1 and clr=0 at clock edge N:
  - lane[sel] <= din; sel and din are sampled at edge N
  - hit <= one-hot(sel); last <= sel; wcnt <= wcnt+1 (mod 256)
  - New lane value and hit are visible after edge N, so latency is 1 cycle from the wr rise
  - Other lanes keep their values
- hit returns to 0 at edge N+1 unless another wr_edge occurs there. Back-to-back writes need wr to go low for at least one sampled cycle.
- wr held high for many cycles produces exactly one write.
- Writing the same lane twice: the latest value wins and every write is counted.
- clr=1 at an edge:
  - all lanes <= 0, hit <= 0
  - any simultaneous wr_edge is discarded: no lane write, no count, last unchanged
  - wr_q still updates, so that edge is consumed
- last and wcnt are not affected by clr; only rst clears them.
- sel, din, and clr are synchronous inputs and are assumed stable at the sampling edge.
- No state machine beyond edge detect and the optional scan counter; no back-pressure, since a write always completes.

Optional Feature:
- Macro SCAN_EN.
- Defined:
  - An 8-bit prescaler counts 0..SCAN_DIV-1.
  - On terminal count, scan_idx advances 0->1->2->3->0 and the prescaler restarts.
  - scan_f = lane[scan_idx], registered and updated on the same edge as scan_idx, so it shows post-write lane contents one cycle later.
  - clr resets the prescaler and scan_idx to 0.
  - SCAN_DIV=1 steps every cycle.
- Not defined: scan_f and scan_idx ports, prescaler, and scan registers are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - lane-count constant NLANE=4
  - 2-bit lane-index typedef
  - default DW constant
  - the shared one-hot decode function, also used by hit generation
- One natural sub-module: edge_rise (wr synchronizer-free rising-edge detector, reset-to-1 option), reusable for the board's button inputs.
- Scan logic stays inline under the macro.

Test Plan:
- Reset release with wr=1 held -> no write; f=0, hit=0, wcnt=0.
- sel=2, din=2'b11, wr 0->1 held 5 cycles -> f=8'b00_11_00_00 one cycle after the rise, hit=4'b0100 for 1 cycle only, last=2, wcnt=1.
- Four writes (sel 0..3, din 1,2,3,0), wr low 1 cycle between each -> f=8'b00_11_10_01, wcnt=4, hit pulses 0001,0010,0100,1000 in order.
- clr=1 on the same edge as a wr rise (sel=1, din=3) -> all lanes 0, hit=0, wcnt and last unchanged; a subsequent wr rise writes normally.
- 256 writes -> wcnt wraps to 0; assert rst low mid-sequence -> all outputs zero immediately, asynchronously, without waiting for a clock edge.
- SCAN_EN with SCAN_DIV=4 and lanes loaded 1,2,3,0 -> scan_idx steps every 4 cycles, scan_f sequence 1,2,3,0,1…; clr returns scan_idx to 0.
